lfsr_checker: RTL and testbench

Receive-side companion to the 4-bit LFSR pattern generator. It accepts the generator's parallel word stream and self-synchronises to it from any non-zero word. Once synchronised, it checks every subsequent word against its own LFSR model and reports lock status, per-word error pulses and a saturating error count. It sits at the sink end of the pattern path, so the bench and the on-board capture path can verify the stream without a golden file.

---
 rtl/lfsr_checker_if.sv | 24 ++
 rtl/lfsr_checker.sv | 122 ++++++++++++
 tb/tb_lfsr_checker.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/lfsr_checker_if.sv
// Parallel word bus between an LFSR pattern source and the lfsr_checker sink.
// The source drives the word, valid and error-clear; the checker returns its status.
interface lfsr_checker_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 16
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             err_clr;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] expected;

  modport master (
    output din, din_valid, err_clr,
    input  locked, err, err_count, expected
  );

  modport slave (
    input  din, din_valid, err_clr,
    output locked, err, err_count, expected
  );
endinterface

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: seeds from any non-zero word, locks after LOCK_CNT
// matches, then free-runs its own model and counts mismatches until LOSS_CNT in a row.
module lfsr_checker #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAPS     = 4'b1001,
  parameter int               LOCK_CNT = 4,
  parameter int               LOSS_CNT = 3,
  parameter int               ERR_W    = 16
) (
  input logic           clk,
  input logic           reset,
  lfsr_checker_if.slave bus
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;

  logic [MW-1:0]    match_inc;
  logic [LW-1:0]    miss_inc;
  logic             hit;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], ^(x & TAPS)};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + ERR_W'(1);
  endfunction

  assign match_inc = match_q + MW'(1);
  assign miss_inc  = miss_q + LW'(1);
  assign hit       = (bus.din == expected_q);

  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    miss_d     = miss_q;
    expected_d = expected_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;

    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          // All-zero is the lock-up word and can never seed a valid sequence.
          if (bus.din != '0) begin
            expected_d = lfsr_next(bus.din);
            match_d    = '0;
            state_d    = CHECK;
          end
        end
        CHECK: begin
          if (hit) begin
            match_d    = match_inc;
            expected_d = lfsr_next(expected_q);
            if (match_inc == MW'(LOCK_CNT)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (bus.din == '0) begin
            state_d = HUNT;
          end else begin
            expected_d = lfsr_next(bus.din);
            match_d    = '0;
          end
        end
        LOCKED: begin
          expected_d = lfsr_next(expected_q);
          if (hit) begin
            miss_d = '0;
          end else begin
            err_d  = 1'b1;
            cnt_d  = sat_inc(cnt_q);
            miss_d = miss_inc;
            if (miss_inc == LW'(LOSS_CNT)) begin
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // Clear takes priority over a coincident increment.
    if (bus.err_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      match_q    <= '0;
      miss_q     <= '0;
      expected_q <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      expected_q <= expected_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err       = err_q;
  assign bus.err_count = cnt_q;
  assign bus.expected  = expected_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: default instance for lock/check/loss/gaps,
// a narrow-counter instance for saturation, clear priority and mid-CHECK reset.
module tb_lfsr_checker;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   n_vec  = 0;
  int   n_miss = 0;

  // Generator sequence for TAPS=1001 starting at 0001.
  logic [3:0] seq [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                           4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

  lfsr_checker_if #(.WIDTH(4), .ERR_W(16)) b0 ();
  lfsr_checker_if #(.WIDTH(4), .ERR_W(2))  b1 ();

  lfsr_checker #(.WIDTH(4), .TAPS(4'b1001), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut0 (
    .clk(clk), .reset(rst0), .bus(b0.slave)
  );

  lfsr_checker #(.WIDTH(4), .TAPS(4'b1001), .LOCK_CNT(4), .LOSS_CNT(8), .ERR_W(2)) dut1 (
    .clk(clk), .reset(rst1), .bus(b1.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic drv0(input logic v, input logic [3:0] d, input logic c);
    b0.din_valid = v;
    b0.din       = d;
    b0.err_clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic v, input logic [3:0] d, input logic c);
    b1.din_valid = v;
    b1.din       = d;
    b1.err_clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    drv0(1'b0, 4'h0, 1'b0);
    rst0 = 1'b0;
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    b0.din_valid = 1'b0; b0.din = '0; b0.err_clr = 1'b0;
    b1.din_valid = 1'b0; b1.din = '0; b1.err_clr = 1'b0;
    #1;
    drv0(1'b0, 4'h0, 1'b0);
    rst0 = 1'b0;
    check("rst_locked", b0.locked, 0);
    check("rst_err", b0.err, 0);
    check("rst_cnt", b0.err_count, 0);
    check("rst_exp", b0.expected, 0);

    // Back-to-back lock on the first five words.
    for (int i = 0; i < 5; i++) begin
      drv0(1'b1, seq[i], 1'b0);
      check($sformatf("lock_err%0d", i), b0.err, 0);
      check($sformatf("lock_lk%0d", i), b0.locked, (i == 4) ? 1 : 0);
    end
    check("lock_exp", b0.expected, 4'hD);
    check("lock_cnt", b0.err_count, 0);

    // Single corrupted word while locked.
    drv0(1'b1, seq[5], 1'b0);
    drv0(1'b1, 4'hB, 1'b0);
    check("bad1_err", b0.err, 1);
    check("bad1_cnt", b0.err_count, 1);
    check("bad1_lk", b0.locked, 1);
    check("bad1_exp", b0.expected, 4'h5);
    drv0(1'b0, 4'h0, 1'b0);
    check("gap_err", b0.err, 0);
    check("gap_exp", b0.expected, 4'h5);
    drv0(1'b1, seq[7], 1'b0);
    check("good_err", b0.err, 0);
    check("good_cnt", b0.err_count, 1);
    check("good_lk", b0.locked, 1);

    // Clear, then three corrupted words lose lock.
    drv0(1'b0, 4'h0, 1'b1);
    check("clr_cnt", b0.err_count, 0);
    for (int i = 0; i < 3; i++) begin
      drv0(1'b1, ~seq[8 + i], 1'b0);
      check($sformatf("loss_err%0d", i), b0.err, 1);
      check($sformatf("loss_cnt%0d", i), b0.err_count, i + 1);
      check($sformatf("loss_lk%0d", i), b0.locked, (i == 2) ? 0 : 1);
    end
    check("loss_exp", b0.expected, 4'h9);

    // Zero words in HUNT are ignored and expected holds.
    for (int i = 0; i < 10; i++) drv0(1'b1, 4'h0, 1'b0);
    check("zero_lk", b0.locked, 0);
    check("zero_exp", b0.expected, 4'h9);
    check("zero_err", b0.err, 0);

    // Relock from a fresh seed plus four successors.
    drv0(1'b1, 4'h7, 1'b0);
    check("reseed_exp", b0.expected, 4'hF);
    drv0(1'b1, 4'hF, 1'b0);
    drv0(1'b1, 4'hE, 1'b0);
    drv0(1'b1, 4'hD, 1'b0);
    check("relock_pre", b0.locked, 0);
    drv0(1'b1, 4'hA, 1'b0);
    check("relock_lk", b0.locked, 1);
    check("relock_exp", b0.expected, 4'h5);

    // Mismatch in CHECK reseeds silently.
    reset0();
    drv0(1'b1, 4'h1, 1'b0);
    drv0(1'b1, 4'h5, 1'b0);
    check("chk_err", b0.err, 0);
    check("chk_cnt", b0.err_count, 0);
    check("chk_exp", b0.expected, 4'hB);
    drv0(1'b1, 4'hB, 1'b0);
    drv0(1'b1, 4'h6, 1'b0);
    drv0(1'b1, 4'hC, 1'b0);
    check("chk_pre", b0.locked, 0);
    drv0(1'b1, 4'h9, 1'b0);
    check("chk_lk", b0.locked, 1);
    check("chk_exp2", b0.expected, 4'h2);

    // Zero in CHECK returns to HUNT, so 0011 becomes a new seed.
    reset0();
    drv0(1'b1, 4'h1, 1'b0);
    drv0(1'b1, 4'h0, 1'b0);
    check("chk0_exp", b0.expected, 4'h3);
    drv0(1'b1, 4'h3, 1'b0);
    drv0(1'b1, 4'h7, 1'b0);
    drv0(1'b1, 4'hF, 1'b0);
    drv0(1'b1, 4'hE, 1'b0);
    check("chk0_pre", b0.locked, 0);
    drv0(1'b1, 4'hD, 1'b0);
    check("chk0_lk", b0.locked, 1);

    // Lock with 0..3 idle cycles between words.
    reset0();
    for (int i = 0; i < 5; i++) begin
      for (int g = 0; g < (i % 4); g++) begin
        drv0(1'b0, 4'hF, 1'b0);
        check($sformatf("gap_hold%0d_%0d", i, g), b0.expected, (i == 0) ? 4'h0 : seq[i]);
      end
      check($sformatf("gap_lk%0d", i), b0.locked, 0);
      drv0(1'b1, seq[i], 1'b0);
    end
    check("gap_lock", b0.locked, 1);
    check("gap_exp_end", b0.expected, 4'hD);

    // Narrow counter: saturation, clear priority, reset mid-CHECK.
    drv1(1'b0, 4'h0, 1'b0);
    rst1 = 1'b0;
    for (int i = 0; i < 5; i++) drv1(1'b1, seq[i], 1'b0);
    check("sat_lock", b1.locked, 1);
    for (int i = 0; i < 5; i++) begin
      drv1(1'b1, seq[5 + i] ^ 4'hF, 1'b0);
      check($sformatf("sat_cnt%0d", i), b1.err_count, (i < 3) ? i + 1 : 3);
      check($sformatf("sat_lk%0d", i), b1.locked, 1);
    end
    drv1(1'b1, seq[10] ^ 4'hF, 1'b1);
    check("clrwin_cnt", b1.err_count, 0);
    check("clrwin_err", b1.err, 1);
    drv1(1'b1, seq[11] ^ 4'hF, 1'b0);
    check("miss7_cnt", b1.err_count, 1);
    check("miss7_lk", b1.locked, 1);
    drv1(1'b1, seq[12] ^ 4'hF, 1'b0);
    check("miss8_lk", b1.locked, 0);
    check("miss8_cnt", b1.err_count, 2);
    drv1(1'b1, 4'h1, 1'b0);
    check("mid_exp", b1.expected, 4'h3);
    rst1 = 1'b1;
    drv1(1'b1, 4'h3, 1'b0);
    rst1 = 1'b0;
    check("mid_lk", b1.locked, 0);
    check("mid_err", b1.err, 0);
    check("mid_cnt", b1.err_count, 0);
    check("mid_exp0", b1.expected, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
